// File: rtl/tick_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tick_ctrl
//  Purpose  : Programmable tick sequencer. A start/stop/hold controller around
//             an internal divider that emits a 1-cycle tick every P_eff clocks
//             (P_eff = latched period, or 1 when that is 0), optionally for a
//             bounded number of ticks (n_ticks, 0 = free-run).
//  Revision : 1.0 - initial release
//
//  Ports
//    clk       in   system clock, rising edge
//    reset     in   asynchronous, active-low reset
//    start     in   begin a sequence (accepted in IDLE/DONE only)
//    stop      in   abort the sequence, highest priority
//    hold      in   pause the divider while high
//    period    in   [PERIOD_W] tick interval, latched on accepted start
//    n_ticks   in   [CNT_W] tick limit, 0 = free-run, latched on start
//    tick      out  registered 1-cycle tick pulse
//    busy      out  high in RUN or HOLD
//    done      out  1-cycle pulse coincident with the final tick
//    tick_cnt  out  [CNT_W] ticks issued since the last accepted start
//
//  Build option
//    TICK_CTRL_AUTORELOAD_EN : when defined, the final tick pulses done,
//                              clears tick_cnt and keeps running with the
//                              same latched configuration (DONE unreachable).
// ============================================================================
module tick_ctrl #(
    parameter int PERIOD_W = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                hold,
    input  logic [PERIOD_W-1:0] period,
    input  logic [CNT_W-1:0]    n_ticks,
    output logic                tick,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    tick_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state;
    logic [PERIOD_W-1:0] period_q;
    logic [CNT_W-1:0]    n_q;
    logic [PERIOD_W-1:0] div;

    logic [PERIOD_W-1:0] wrap_val;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last_tick;

    // A latched period of 0 behaves like 1: tick on every running cycle.
    assign wrap_val  = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
    assign cnt_inc   = tick_cnt + CNT_W'(1);
    assign last_tick = (n_q != '0) && (cnt_inc == n_q);

    assign busy = (state == S_RUN) || (state == S_HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            period_q <= '0;
            n_q      <= '0;
            div      <= '0;
            tick     <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !stop) begin
                        state    <= S_RUN;
                        period_q <= period;
                        n_q      <= n_ticks;
                        div      <= '0;
                        tick_cnt <= '0;
                    end
                end
                S_RUN, S_HOLD: begin
                    if (stop) begin
                        state <= S_IDLE;
                        div   <= '0;
                    end else if (hold) begin
                        state <= S_HOLD;
                    end else begin
                        // hold acts as a divider enable: the edge that leaves
                        // HOLD already counts, so a hold of N cycles delays
                        // the next tick by exactly N cycles.
                        state <= S_RUN;
                        if (div == wrap_val) begin
                            div      <= '0;
                            tick     <= 1'b1;
                            tick_cnt <= cnt_inc;
                            if (last_tick) begin
                                done <= 1'b1;
`ifdef TICK_CTRL_AUTORELOAD_EN
                                tick_cnt <= '0;
`else
                                state    <= S_DONE;
`endif
                            end
                        end else begin
                            div <= div + PERIOD_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
